adt7420_i2c_responder: RTL and testbench

//  I2C target emulating the ADT7420 temperature sensor: answers pointer writes and register reads.

---
 rtl/adt7420_i2c_responder_pkg.sv | 40 ++++
 rtl/adt7420_i2c_responder_line_filter.sv | 71 +++++++
 rtl/adt7420_i2c_responder.sv | 207 ++++++++++++++++++++
 tb/tb_adt7420_i2c_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adt7420_i2c_responder_pkg.sv
// Shared definitions for the ADT7420 I2C responder.
//  - Register pointer addresses served by the responder.
//  - FSM state encoding (also exported on the top's dbg_state port).
//  - reg_read(): read-side register map, used to load the next TX byte.
package adt7420_i2c_responder_pkg;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_TX        = 4'd7,
        ST_TX_ACK    = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // Temperature bytes come from the per-transfer snapshot, never from the
    // live input, so MSB and LSB of one read always belong together.
    function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                            input logic [15:0] snap,
                                            input logic [7:0]  cfg,
                                            input logic [7:0]  id);
        case (ptr)
            REG_TEMP_MSB: return snap[15:8];
            REG_TEMP_LSB: return snap[7:0];
            REG_CONFIG:   return cfg;
            REG_ID:       return id;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/adt7420_i2c_responder_line_filter.sv
// i2c_line_filter: conditions the raw SCL/SDA pins for the responder.
//  - 2-flop synchronizer per line.
//  - Glitch filter: a filtered level only changes after FILT_LEN consecutive
//    synchronized samples disagree with it.
//  - Strobes (one clk wide): scl_rise, scl_fall, start_det, stop_det.
// Ports:
//  clk, rst          system clock, synchronous active-high reset
//  scl_raw, sda_raw  asynchronous pin levels
//  scl_f, sda_f      filtered levels
//  scl_rise/scl_fall filtered SCL edges
//  start_det         SDA fell while SCL high
//  stop_det          SDA rose while SCL high
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int CW = $clog2(FILT_LEN + 1);

    // Bit 0 = SCL, bit 1 = SDA.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus is high on both lines.
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1  <= {sda_raw, scl_raw};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    // SCL must be high both before and after the SDA change.
    assign start_det = filt_d[1] & ~filt[1] & filt[0] & filt_d[0];
    assign stop_det  = ~filt_d[1] & filt[1] & filt[0] & filt_d[0];

endmodule

// File: rtl/adt7420_i2c_responder.sv
// adt7420_i2c_responder: I2C target emulating an ADT7420 temperature sensor.
// Answers pointer writes and register reads; never stretches SCL.
// Ports:
//  CLK100MHZ   system clock (only clock)
//  rst         synchronous active-high reset
//  scl_in      raw SCL pin
//  sda_in      raw SDA pin
//  sda_oe      1 = pull SDA low (open drain)
//  temp_word   live temperature, {temp[12:0], 3'b000}
//  config_reg  register 0x03 contents
//  busy        1 from START until STOP
//  addr_hit    one-cycle pulse when our address is ACKed
//  dbg_state   current FSM state (state_t encoding)
//
// Bit framing: SDA is sampled on filtered SCL rises (bit_cnt counts them).
// Every change of sda_oe happens on a filtered SCL fall and is registered,
// so it lands at least one clock after the fall is seen. An ACK state is
// entered on the fall after the 8th rise and left on the following fall,
// so it covers exactly the 9th SCL period.
module adt7420_i2c_responder
    import adt7420_i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter int         FILT_LEN = 4,
    parameter logic [7:0] ID_VALUE = 8'hCB
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_word,
    output logic [7:0]  config_reg,
    output logic        busy,
    output logic        addr_hit,
    output logic [3:0]  dbg_state
);

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk       (CLK100MHZ),
        .rst       (rst),
        .scl_raw   (scl_in),
        .sda_raw   (sda_in),
        .scl_f     (scl_f),
        .sda_f     (sda_f),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift_sr, shift_sr_n;
    logic [7:0]  pointer, pointer_n;
    logic [7:0]  config_n;
    logic [15:0] temp_snap, temp_snap_n;
    logic [7:0]  tx_byte, tx_byte_n;
    logic        sda_oe_n, addr_hit_n;
    logic [7:0]  pointer_inc, rd_cur, rd_next;

    assign pointer_inc = pointer + 8'd1;
    assign rd_cur      = reg_read(pointer, temp_snap, config_reg, ID_VALUE);
    assign rd_next     = reg_read(pointer_inc, temp_snap, config_reg, ID_VALUE);

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift_sr   <= 8'h00;
            pointer    <= 8'h00;
            config_reg <= 8'h00;
            temp_snap  <= 16'h0000;
            tx_byte    <= 8'h00;
            sda_oe     <= 1'b0;
            addr_hit   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_sr   <= shift_sr_n;
            pointer    <= pointer_n;
            config_reg <= config_n;
            temp_snap  <= temp_snap_n;
            tx_byte    <= tx_byte_n;
            sda_oe     <= sda_oe_n;
            addr_hit   <= addr_hit_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_sr_n  = shift_sr;
        pointer_n   = pointer;
        config_n    = config_reg;
        temp_snap_n = temp_snap;
        tx_byte_n   = tx_byte;
        sda_oe_n    = sda_oe;
        addr_hit_n  = 1'b0;

        if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
        end else if (start_det) begin
            // Also covers repeated START; the pointer is deliberately kept.
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_sr_n = {shift_sr[6:0], sda_f};
                        bit_cnt_n  = bit_cnt + 4'd1;
                        // 8th address bit of a matching read: freeze temperature.
                        if (state == ST_ADDR && bit_cnt == 4'd7 &&
                            shift_sr[6:0] == DEV_ADDR && sda_f) begin
                            temp_snap_n = temp_word;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ST_ADDR) begin
                            if (shift_sr[7:1] == DEV_ADDR) begin
                                state_n    = ST_ADDR_ACK;
                                sda_oe_n   = 1'b1;
                                addr_hit_n = 1'b1;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else if (state == ST_PTR) begin
                            pointer_n = shift_sr;
                            state_n   = ST_PTR_ACK;
                            sda_oe_n  = 1'b1;
                        end else begin
                            state_n  = ST_WDATA_ACK;
                            sda_oe_n = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 4'd0;
                        // shift_sr[0] still holds the R/W bit.
                        if (shift_sr[0]) begin
                            state_n   = ST_TX;
                            tx_byte_n = rd_cur;
                            sda_oe_n  = ~rd_cur[7];
                        end else begin
                            state_n  = ST_PTR;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        state_n   = ST_WDATA;
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b0;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (pointer == REG_CONFIG) begin
                            config_n = shift_sr;
                        end
                        pointer_n = pointer_inc;
                        state_n   = ST_WDATA;
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b0;
                    end
                end
                ST_TX: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = ST_TX_ACK;
                            sda_oe_n = 1'b0;
                        end else begin
                            // After k rises the next bit is index 7-k.
                            sda_oe_n = ~tx_byte[~bit_cnt[2:0]];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && sda_f) begin
                        state_n = ST_IGNORE;
                    end else if (scl_fall) begin
                        pointer_n = pointer_inc;
                        tx_byte_n = rd_next;
                        sda_oe_n  = ~rd_next[7];
                        bit_cnt_n = 4'd0;
                        state_n   = ST_TX;
                    end
                end
                default: begin
                    // IDLE and IGNORE only leave on START/STOP.
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adt7420_i2c_responder.sv
// Bench for adt7420_i2c_responder: bit-level I2C master model with an
// open-drain SDA wire, a scoreboard (expected queue + observed queue) and a
// monitor that pops and compares whenever an observation is presented.
// Time unit: 1 ns per delay step (clock period 10).
module tb_adt7420_i2c_responder;

    logic        clk;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] temp_word;
    logic [7:0]  config_reg;
    logic        busy;
    logic        addr_hit;
    logic [3:0]  dbg_state;

    assign sda_line = sda_m & ~sda_oe;

    adt7420_i2c_responder dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_word  (temp_word),
        .config_reg (config_reg),
        .busy       (busy),
        .addr_hit   (addr_hit),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    string       name_q[$];
    int          n_compared = 0;
    int          n_mismatch = 0;

    task automatic expect_val(input string nm, input logic [15:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [15:0] v);
        obs_q.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        expect_val(nm, exp);
        observe(got);
    endtask

    initial begin : monitor
        logic [15:0] e, o;
        string       nm;
        forever begin
            @(posedge clk);
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                o  = obs_q.pop_front();
                nm = name_q.pop_front();
                n_compared++;
                if (o !== e) begin
                    n_mismatch++;
                    $display("FAIL %s: got %h expected %h", nm, o, e);
                end
            end
        end
    end

    // Background counters for pulses the bench must account for.
    int hit_cnt = 0;
    int oe_cnt  = 0;
    always @(posedge clk) begin
        if (addr_hit) hit_cnt++;
        if (sda_oe)   oe_cnt++;
    end

    // ---------------- driver tasks ----------------
    int q_ns = 1250;  // quarter SCL period; 1250 -> 200 kHz

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; #(q_ns);
            scl_m = 1'b1; #(q_ns);
        end
        sda_m = 1'b0; #(q_ns);
        scl_m = 1'b0; #(q_ns);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(q_ns);
        scl_m = 1'b1; #(q_ns);
        sda_m = 1'b1; #(2 * q_ns);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    #(q_ns);
        scl_m = 1'b1; #(2 * q_ns);
        scl_m = 1'b0; #(q_ns);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #(q_ns);
        scl_m = 1'b1; #(q_ns);
        b = sda_line; #(q_ns);
        scl_m = 1'b0; #(q_ns);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string nm);
        logic a;
        expect_val(nm, {15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        observe({15'd0, a});
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic nack, input string nm);
        logic [7:0] d;
        logic       b;
        d = 8'h00;
        expect_val(nm, {8'h00, exp_d});
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
        observe({8'h00, d});
    endtask

    // Pointer write followed by repeated START and read address.
    task automatic set_ptr_read(input logic [7:0] ptr);
        i2c_start();
        write_byte(8'h96, 1'b0, "ack_addr_w");
        write_byte(ptr,   1'b0, "ack_ptr");
        i2c_start();
        write_byte(8'h97, 1'b0, "ack_addr_r");
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int hit0, oe0;
        rst       = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        temp_word = 16'h0C80;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Reset state
        check("rst_sda_oe",   {15'd0, sda_oe},   16'h0000);
        check("rst_busy",     {15'd0, busy},     16'h0000);
        check("rst_addr_hit", {15'd0, addr_hit}, 16'h0000);
        check("rst_config",   {8'd0, config_reg}, 16'h0000);
        check("rst_state",    {12'd0, dbg_state}, 16'h0000);

        // 1: 200 kHz, ptr 0x00, rep-START, read 0x0C / 0x80
        hit0 = hit_cnt;
        set_ptr_read(8'h00);
        check("t1_busy", {15'd0, busy}, 16'h0001);
        read_byte(8'h0C, 1'b0, "t1_msb");
        read_byte(8'h80, 1'b1, "t1_lsb");
        check("t1_oe_after_nack", {15'd0, sda_oe}, 16'h0000);
        i2c_stop();
        check("t1_hits", 16'(hit_cnt - hit0), 16'd2);
        check("t1_busy_after_stop", {15'd0, busy}, 16'h0000);

        q_ns = 250;  // 1 MHz for the remaining tests

        // 2: wrong address 0x48
        hit0 = hit_cnt;
        oe0  = oe_cnt;
        i2c_start();
        write_byte(8'h90, 1'b1, "t2_nack_addr");
        check("t2_busy_before_stop", {15'd0, busy}, 16'h0001);
        i2c_stop();
        check("t2_busy_after_stop", {15'd0, busy}, 16'h0000);
        check("t2_hits", 16'(hit_cnt - hit0), 16'd0);
        check("t2_oe_cycles", 16'(oe_cnt - oe0), 16'd0);

        // 3: config write / readback, ID read
        i2c_start();
        write_byte(8'h96, 1'b0, "t3_ack_addr");
        write_byte(8'h03, 1'b0, "t3_ack_ptr");
        write_byte(8'hA0, 1'b0, "t3_ack_data");
        i2c_stop();
        check("t3_config_reg", {8'd0, config_reg}, 16'h00A0);
        set_ptr_read(8'h03);
        read_byte(8'hA0, 1'b1, "t3_cfg_read");
        i2c_stop();
        set_ptr_read(8'h0B);
        read_byte(8'hCB, 1'b1, "t3_id_read");
        i2c_stop();

        // 4: snapshot coherency
        temp_word = 16'h0C80;
        set_ptr_read(8'h00);
        read_byte(8'h0C, 1'b0, "t4_msb");
        temp_word = 16'h0D00;
        read_byte(8'h80, 1'b1, "t4_lsb_snap");
        i2c_stop();
        temp_word = 16'h0C80;

        // 5: glitches, then reset mid-TX
        sda_m = 1'b0; #20; sda_m = 1'b1;
        #(q_ns);
        check("t5_sda_glitch_busy", {15'd0, busy}, 16'h0000);
        scl_m = 1'b0; #20; scl_m = 1'b1;
        #(q_ns);
        check("t5_scl_glitch_state", {12'd0, dbg_state}, 16'h0000);
        set_ptr_read(8'h00);
        // MSB 0x0C starts with a 0 bit, so the DUT is pulling SDA now.
        check("t5_tx_driving", {15'd0, sda_oe}, 16'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_oe",     {15'd0, sda_oe},    16'h0000);
        check("t5_rst_state",  {12'd0, dbg_state}, 16'h0000);
        check("t5_rst_config", {8'd0, config_reg}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        i2c_stop();

        // 6: auto-increment through unimplemented regs and pointer wrap
        set_ptr_read(8'h01);
        read_byte(8'h80, 1'b0, "t6_ptr01");
        read_byte(8'h00, 1'b0, "t6_ptr02");
        read_byte(8'h00, 1'b1, "t6_ptr03_cfg0");
        i2c_stop();
        set_ptr_read(8'hFF);
        read_byte(8'h00, 1'b0, "t6_ptrFF");
        read_byte(8'h0C, 1'b1, "t6_wrap_msb");
        i2c_stop();

        // drain scoreboard (bounded)
        for (int i = 0; i < 50 && obs_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0",
                     exp_q.size(), obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
